// File: rtl/sd_emmc_pkg.sv
// Shared types and constants for the SD/eMMC command arbiter.
// Covers FSM states, requester indices, status bit positions and setting encodings.
package sd_emmc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_FIN  = 3'd2,
    ST_BUSY_GAP  = 3'd3,
    ST_WAIT_BUSY = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  localparam int REQ_INIT = 0;
  localparam int REQ_NEG  = 1;
  localparam int REQ_AUTO = 2;
  localparam int REQ_USER = 3;

  localparam int STAT_CRC_OK   = 0;
  localparam int STAT_INDEX_OK = 1;
  localparam int STAT_FIN_TO   = 2;
  localparam int STAT_BUSY_TO  = 3;

  localparam logic [1:0] SET_NO_RESP = 2'b00;
  localparam logic [1:0] SET_SHORT   = 2'b01;
  localparam logic [1:0] SET_LONG    = 2'b11;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    onehot_to_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) onehot_to_idx = 2'(i);
    end
  endfunction

endpackage

// File: rtl/sd_emmc_rr_pick.sv
// Combinational round-robin pick among requesters 1-3.
// The search starts after last_i and wraps 3 -> 1.
module sd_emmc_rr_pick
  import sd_emmc_pkg::*;
(
  input  logic [3:1] req_i,
  input  logic [1:0] last_i,
  output logic [3:1] pick_o,
  output logic       valid_o
);

  always_comb begin
    pick_o  = 3'b000;
    valid_o = |req_i;
    case (last_i)
      2'd1: begin
        if      (req_i[REQ_AUTO]) pick_o[REQ_AUTO] = 1'b1;
        else if (req_i[REQ_USER]) pick_o[REQ_USER] = 1'b1;
        else if (req_i[REQ_NEG])  pick_o[REQ_NEG]  = 1'b1;
      end
      2'd2: begin
        if      (req_i[REQ_USER]) pick_o[REQ_USER] = 1'b1;
        else if (req_i[REQ_NEG])  pick_o[REQ_NEG]  = 1'b1;
        else if (req_i[REQ_AUTO]) pick_o[REQ_AUTO] = 1'b1;
      end
      default: begin
        if      (req_i[REQ_NEG])  pick_o[REQ_NEG]  = 1'b1;
        else if (req_i[REQ_AUTO]) pick_o[REQ_AUTO] = 1'b1;
        else if (req_i[REQ_USER]) pick_o[REQ_USER] = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sd_emmc_cmd_arbiter.sv
// Request/grant scheduler for the single command serial host.
// Sequences issue, finish wait, optional R1b busy wait and completion status per transaction.
module sd_emmc_cmd_arbiter
  import sd_emmc_pkg::*;
#(
  parameter int FIN_TIMEOUT  = 4096,
  parameter int BUSY_GAP     = 8,
  parameter int BUSY_TIMEOUT = 1048576,
  parameter int CNT_W        = 21
) (
  input  logic         sd_clk,
  input  logic         sd_rst_n,
  input  logic         init_done_i,
  input  logic [3:0]   req_i,
  input  logic [3:0]   busy_chk_i,
  input  logic [7:0]   setting_req_i,
  input  logic [159:0] cmd_req_i,
  output logic [3:0]   grant_o,
  output logic [3:0]   done_o,
  output logic [3:0]   status_o,
  output logic [119:0] response_o,
  output logic [1:0]   setting_o,
  output logic [39:0]  cmd_o,
  output logic         start_xfr_o,
  input  logic         command_inhibit_i,
  input  logic         finish_i,
  input  logic         crc_ok_i,
  input  logic         index_ok_i,
  input  logic [119:0] response_i,
  input  logic         busy_i,
  output state_e       state_o
);

  localparam logic [CNT_W-1:0] FIN_LAST  = CNT_W'(FIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(BUSY_GAP - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [3:0]         grant_q, grant_d;
  logic [1:0]         setting_q, setting_d;
  logic [39:0]        cmd_q, cmd_d;
  logic               busy_chk_q, busy_chk_d;
  logic [3:0]         pend_q, pend_d;
  logic [3:0]         status_q, status_d;
  logic [119:0]       response_q, response_d;
  logic               start_q, start_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [3:0]         elig;
  logic [3:1]         rr_pick;
  logic               rr_valid;
  logic [3:0]         win;
  logic [1:0]         win_idx;
  logic [CNT_W-1:0]   cnt_inc;

  // Before init completes only the init requester may compete.
  assign elig = init_done_i ? req_i : {3'b000, req_i[REQ_INIT]};

  sd_emmc_rr_pick u_rr_pick (
    .req_i   (elig[3:1]),
    .last_i  (rr_ptr_q),
    .pick_o  (rr_pick),
    .valid_o (rr_valid)
  );

  always_comb begin
    win = 4'b0000;
    if (elig[REQ_INIT])  win[REQ_INIT] = 1'b1;
    else if (rr_valid)   win = {rr_pick, 1'b0};
  end

  assign win_idx = onehot_to_idx(win);
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // Host handshake: start_xfr_o is a one-cycle strobe issued only while
  // command_inhibit_i is low; finish_i is honoured only in ST_WAIT_FIN.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    setting_d  = setting_q;
    cmd_d      = cmd_q;
    busy_chk_d = busy_chk_q;
    pend_d     = pend_q;
    status_d   = status_q;
    response_d = response_q;
    start_d    = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (|win) begin
          grant_d    = win;
          setting_d  = setting_req_i[2*int'(win_idx) +: 2];
          cmd_d      = cmd_req_i[40*int'(win_idx) +: 40];
          busy_chk_d = busy_chk_i[win_idx];
          pend_d     = 4'b0000;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!command_inhibit_i) begin
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT_FIN;
        end
      end
      ST_WAIT_FIN: begin
        if (finish_i) begin
          response_d            = response_i;
          pend_d[STAT_CRC_OK]   = crc_ok_i;
          pend_d[STAT_INDEX_OK] = index_ok_i;
          cnt_d                 = '0;
          state_d               = busy_chk_q ? ST_BUSY_GAP : ST_DONE;
        end else if (cnt_q == FIN_LAST) begin
          pend_d              = 4'b0000;
          pend_d[STAT_FIN_TO] = 1'b1;
          state_d             = ST_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_BUSY_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT_BUSY;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT_BUSY: begin
        if (busy_i) begin
          state_d = ST_DONE;
        end else if (cnt_q == BUSY_LAST) begin
          pend_d[STAT_BUSY_TO] = 1'b1;
          state_d              = ST_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DONE: begin
        if (!grant_q[REQ_INIT]) rr_ptr_d = onehot_to_idx(grant_q);
        grant_d    = 4'b0000;
        setting_d  = SET_NO_RESP;
        cmd_d      = '0;
        busy_chk_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Status becomes visible in the same cycle as the done pulse.
    if (state_d == ST_DONE && state_q != ST_DONE) status_d = pend_d;
  end

  always_ff @(posedge sd_clk or negedge sd_rst_n) begin
    if (!sd_rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= 4'b0000;
      setting_q  <= 2'b00;
      cmd_q      <= '0;
      busy_chk_q <= 1'b0;
      pend_q     <= 4'b0000;
      status_q   <= 4'b0000;
      response_q <= '0;
      start_q    <= 1'b0;
      rr_ptr_q   <= 2'd3;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      setting_q  <= setting_d;
      cmd_q      <= cmd_d;
      busy_chk_q <= busy_chk_d;
      pend_q     <= pend_d;
      status_q   <= status_d;
      response_q <= response_d;
      start_q    <= start_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign grant_o     = grant_q;
  assign done_o      = (state_q == ST_DONE) ? grant_q : 4'b0000;
  assign status_o    = status_q;
  assign response_o  = response_q;
  assign setting_o   = setting_q;
  assign cmd_o       = cmd_q;
  assign start_xfr_o = start_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_sd_emmc_cmd_arbiter.sv
// Directed bench for sd_emmc_cmd_arbiter with short timeouts.
// Steps run linearly; outputs are sampled 1 ns after each rising edge.
module tb_sd_emmc_cmd_arbiter;
  import sd_emmc_pkg::*;

  localparam int FIN_TO  = 16;
  localparam int GAP     = 8;
  localparam int BUSY_TO = 256;

  localparam logic [39:0] CMD0 = 40'h40_0000_0000;
  localparam logic [39:0] CMD1 = 40'h46_0000_0002;
  localparam logic [39:0] CMD2 = 40'h51_0000_1000;
  localparam logic [39:0] CMD3 = 40'h58_0000_2000;
  localparam logic [39:0] CMD2_ALT = 40'h52_DEAD_BEEF;

  // clock / reset
  logic sd_clk = 1'b0;
  logic sd_rst_n = 1'b0;
  always #5 sd_clk = ~sd_clk;

  logic         init_done_i = 1'b0;
  logic [3:0]   req_i = 4'b0000;
  logic [3:0]   busy_chk_i = 4'b0000;
  logic [7:0]   setting_req_i = {2'b01, 2'b11, 2'b01, 2'b00};
  logic [159:0] cmd_req_i = {CMD3, CMD2, CMD1, CMD0};
  logic         command_inhibit_i = 1'b0;
  logic         finish_i = 1'b0;
  logic         crc_ok_i = 1'b1;
  logic         index_ok_i = 1'b1;
  logic [119:0] response_i = 120'h0;
  logic         busy_i = 1'b1;

  logic [3:0]   grant_o, done_o, status_o;
  logic [119:0] response_o;
  logic [1:0]   setting_o;
  logic [39:0]  cmd_o;
  logic         start_xfr_o;
  state_e       state_o;

  sd_emmc_cmd_arbiter #(
    .FIN_TIMEOUT (FIN_TO),
    .BUSY_GAP    (GAP),
    .BUSY_TIMEOUT(BUSY_TO),
    .CNT_W       (21)
  ) dut (
    .sd_clk           (sd_clk),
    .sd_rst_n         (sd_rst_n),
    .init_done_i      (init_done_i),
    .req_i            (req_i),
    .busy_chk_i       (busy_chk_i),
    .setting_req_i    (setting_req_i),
    .cmd_req_i        (cmd_req_i),
    .grant_o          (grant_o),
    .done_o           (done_o),
    .status_o         (status_o),
    .response_o       (response_o),
    .setting_o        (setting_o),
    .cmd_o            (cmd_o),
    .start_xfr_o      (start_xfr_o),
    .command_inhibit_i(command_inhibit_i),
    .finish_i         (finish_i),
    .crc_ok_i         (crc_ok_i),
    .index_ok_i       (index_ok_i),
    .response_i       (response_i),
    .busy_i           (busy_i),
    .state_o          (state_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  // driver tasks
  task automatic step();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(output logic [3:0] g);
    g = 4'b0000;
    for (int i = 0; i < 64; i++) begin
      step();
      if (grant_o != 4'b0000) begin
        g = grant_o;
        break;
      end
    end
  endtask

  task automatic wait_start();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (start_xfr_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("start_seen", seen, 1'b1);
  endtask

  task automatic finish_pulse(input int gap);
    repeat (gap) step();
    finish_i = 1'b1;
    step();
    finish_i = 1'b0;
  endtask

  task automatic count_to_done(output int c);
    c = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      c++;
      if (done_o != 4'b0000) break;
    end
  endtask

  logic [3:0] g, e;
  logic       flag;
  int         c;

  initial begin
    // reset state
    repeat (3) step();
    chk("rst_grant", grant_o, 4'b0000);
    chk("rst_done", done_o, 4'b0000);
    chk("rst_status", status_o, 4'b0000);
    chk("rst_cmd", cmd_o, 40'h0);
    chk("rst_start", start_xfr_o, 1'b0);
    chk("rst_state", state_o, ST_IDLE);
    sd_rst_n = 1'b1;
    step();

    // 1: gating before init, then init command
    req_i = 4'b1110;
    repeat (4) step();
    chk("gate_no_grant", grant_o, 4'b0000);
    req_i = 4'b1111;
    step();
    chk("t1_grant", grant_o, 4'b0001);
    chk("t1_cmd", cmd_o, CMD0);
    chk("t1_setting", setting_o, 2'b00);
    chk("t1_start_lo", start_xfr_o, 1'b0);
    req_i = 4'b1110;
    step();
    chk("t1_start_hi", start_xfr_o, 1'b1);
    step();
    chk("t1_start_1cyc", start_xfr_o, 1'b0);
    response_i = 120'h00AB_CDEF_1234;
    finish_pulse(3);
    chk("t1_done", done_o, 4'b0001);
    chk("t1_status", status_o, 4'b0011);
    chk("t1_resp", response_o, 120'h00AB_CDEF_1234);
    step();
    chk("t1_done_1cyc", done_o, 4'b0000);
    chk("t1_grant_clr", grant_o, 4'b0000);
    chk("t1_cmd_clr", cmd_o, 40'h0);
    repeat (3) step();
    chk("t1_still_gated", grant_o, 4'b0000);

    // 2: round robin among 1-3, pointer starts at 3
    init_done_i = 1'b1;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0010);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      wait_grant(g);
      chk($sformatf("t2_grant%0d", i), g, e);
      wait_start();
      finish_pulse(2);
      chk($sformatf("t2_done%0d", i), done_o, e);
    end
    chk("t2_status", status_o, 4'b0011);
    req_i = 4'b0000;

    // 3: inhibit holds off start; req0 waits without preemption
    command_inhibit_i = 1'b1;
    req_i = 4'b0100;
    wait_grant(g);
    chk("t3_grant", g, 4'b0100);
    chk("t3_setting", setting_o, 2'b11);
    req_i = 4'b0001;
    cmd_req_i[80 +: 40] = CMD2_ALT;
    flag = 1'b0;
    repeat (20) begin
      step();
      if (start_xfr_o) flag = 1'b1;
    end
    chk("t3_no_start", flag, 1'b0);
    chk("t3_no_preempt", grant_o, 4'b0100);
    chk("t3_cmd_stable", cmd_o, CMD2);
    command_inhibit_i = 1'b0;
    step();
    chk("t3_start", start_xfr_o, 1'b1);
    step();
    chk("t3_start_1cyc", start_xfr_o, 1'b0);
    finish_pulse(3);
    chk("t3_done", done_o, 4'b0100);
    cmd_req_i[80 +: 40] = CMD2;
    wait_grant(g);
    chk("t3_req0_grant", g, 4'b0001);
    req_i = 4'b0000;
    wait_start();
    finish_pulse(1);
    chk("t3_req0_done", done_o, 4'b0001);

    // 4: finish timeout
    req_i = 4'b0010;
    wait_grant(g);
    chk("t4_grant", g, 4'b0010);
    req_i = 4'b0000;
    wait_start();
    count_to_done(c);
    chk("t4_latency", c, 16);
    chk("t4_done", done_o, 4'b0010);
    chk("t4_status", status_o, 4'b0100);

    // 5a: R1b busy released after 100 cycles
    busy_chk_i = 4'b1000;
    req_i = 4'b1000;
    wait_grant(g);
    chk("t5_grant", g, 4'b1000);
    req_i = 4'b0000;
    wait_start();
    busy_i = 1'b0;
    finish_pulse(2);
    flag = 1'b0;
    repeat (99) begin
      step();
      if (done_o != 4'b0000) flag = 1'b1;
    end
    chk("t5_no_early_done", flag, 1'b0);
    busy_i = 1'b1;
    step();
    chk("t5_done", done_o, 4'b1000);
    chk("t5_status", status_o, 4'b0011);

    // 5b: busy timeout
    step();
    req_i = 4'b1000;
    wait_grant(g);
    chk("t5b_grant", g, 4'b1000);
    req_i = 4'b0000;
    wait_start();
    busy_i = 1'b0;
    finish_pulse(2);
    count_to_done(c);
    chk("t5b_latency", c, GAP + BUSY_TO);
    chk("t5b_done", done_o, 4'b1000);
    chk("t5b_status", status_o, 4'b1011);
    busy_i = 1'b1;
    step();

    // 6: reset in WAIT_BUSY, then pending requester 2
    req_i = 4'b1000;
    wait_grant(g);
    chk("t6_grant", g, 4'b1000);
    req_i = 4'b0100;
    wait_start();
    busy_i = 1'b0;
    finish_pulse(2);
    repeat (20) step();
    chk("t6_in_wait_busy", state_o, ST_WAIT_BUSY);
    #3;
    sd_rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", grant_o, 4'b0000);
    chk("t6_rst_done", done_o, 4'b0000);
    chk("t6_rst_status", status_o, 4'b0000);
    chk("t6_rst_resp", response_o, 120'h0);
    chk("t6_rst_cmd", cmd_o, 40'h0);
    chk("t6_rst_state", state_o, ST_IDLE);
    step();
    sd_rst_n = 1'b1;
    busy_i = 1'b1;
    chk("t6_no_done", done_o, 4'b0000);
    step();
    chk("t6_regrant", grant_o, 4'b0100);
    chk("t6_regrant_cmd", cmd_o, CMD2);
    req_i = 4'b0000;
    busy_chk_i = 4'b0000;
    wait_start();
    finish_pulse(1);
    chk("t6_done", done_o, 4'b0100);
    step();

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not reach summary");
    $fatal(1);
  end

endmodule

// File: doc/sd_emmc_cmd_arbiter.md
Name: sd_emmc_cmd_arbiter

Overview:
Arbitrates the single command serial host between four command requesters: 0 init, 1 speed/width negotiation, 2 auto transfer, 3 user. It replaces the static select-driven command mux with a request/grant scheduler. The block sequences each transaction: issue, wait for finish, optional R1b busy wait, completion status. It sits between the requester blocks and the command serial host, in the sd_clk domain.

Parameters:
FIN_TIMEOUT, 4096, sd_clk cycles allowed from start_xfr_o to finish_i before the finish timeout is flagged
BUSY_GAP, 8, sd_clk cycles after finish before busy_i is sampled
BUSY_TIMEOUT, 1048576, sd_clk cycles allowed for busy_i to return high
CNT_W, 21, width of the shared timeout counter; must satisfy 2^CNT_W > max(FIN_TIMEOUT, BUSY_TIMEOUT)

Ports:
sd_clk  in  1  single clock
sd_rst_n  in  1  asynchronous active-low reset
init_done_i  in  1  card init complete; gates requesters 1-3
req_i  in  4  per-requester request level, bit n = requester n
busy_chk_i  in  4  per-requester R1b busy wait enable, sampled at grant
setting_req_i  in  8  requester n setting at [2n+1:2n]
cmd_req_i  in  160  requester n command at [40n+39:40n]
grant_o  out  4  one-hot owner, held for the whole transaction
done_o  out  4  one-cycle completion pulse to the owner
status_o  out  4  [0] crc_ok, [1] index_ok, [2] fin_timeout, [3] busy_timeout
response_o  out  120  response latched on finish_i
setting_o  out  2  to serial host
cmd_o  out  40  to serial host
start_xfr_o  out  1  one-cycle start to serial host
command_inhibit_i  in  1  serial host busy
finish_i  in  1  serial host finish pulse
crc_ok_i  in  1  serial host CRC result
index_ok_i  in  1  serial host index result
response_i  in  120  serial host response
busy_i  in  1  DAT0; low = card busy

Behaviour:
- Reset (async, sd_rst_n low): state IDLE; all outputs 0; RR pointer 3; counter 0. A reset mid-transaction aborts immediately. No done pulse is generated.
- Eligibility: before init_done_i=1, only req_i[0] is eligible. After it, all four requesters are eligible.
- Priority: requester 0 is fixed highest. Requesters 1-3 are round-robin, with the search starting at last_granted+1 and wrapping 3→1.
- IDLE: if any eligible request is present, set grant_o, capture setting/cmd/busy_chk of the winner into setting_o/cmd_o/busy flag, then go to ISSUE. Latency from req to grant is 1 cycle.
- ISSUE: hold while command_inhibit_i=1. When it is 0, pulse start_xfr_o for 1 cycle, clear the counter, and go to WAIT_FIN.
- WAIT_FIN: on finish_i, latch response_i, crc_ok_i and index_ok_i. If the busy flag is set, go to BUSY_GAP; otherwise go to DONE. If the counter reaches FIN_TIMEOUT-1 without finish_i, set fin_timeout, clear crc_ok/index_ok, and go to DONE.
- BUSY_GAP: count BUSY_GAP cycles, then clear the counter and go to WAIT_BUSY.
- WAIT_BUSY: go to DONE on the first cycle busy_i=1. At BUSY_TIMEOUT-1, set busy_timeout and go to DONE.
- DONE: pulse done_o[owner] for 1 cycle, update status_o, update the RR pointer (only if owner≠0), clear grant_o and setting_o/cmd_o, then go to IDLE.
  - status_o and response_o hold until the next DONE.
  - The next grant is no earlier than the cycle after DONE.
- setting_o and cmd_o are stable from grant through DONE. The owner's changes to its request inputs during a transaction are ignored.
- Owner drops req_i mid-transaction: the transaction still completes and done_o still pulses.
- finish_i while not in WAIT_FIN is ignored.
- Requester 0 arriving while another requester owns the bus waits; there is no preemption.
- init_done_i falling mid-transaction: the transaction completes. Gating applies from the next IDLE.
- Counter saturates; it never wraps.

Decomposition:
- Shared package sd_emmc_pkg holds:
  - state enum (IDLE, ISSUE, WAIT_FIN, BUSY_GAP, WAIT_BUSY, DONE)
  - requester index constants REQ_INIT=0, REQ_NEG=1, REQ_AUTO=2, REQ_USER=3
  - status bit positions
  - setting encodings: 00 no response, 01 short, 11 long
- One natural sub-module: sd_emmc_rr_pick. It is combinational: 3-way round-robin select from request bits and pointer, producing a one-hot output and a valid.

Test Plan:
1. init_done_i=0, req_i=4'b1110 → no grant. Then req_i[0]=1 with cmd 40'h40_0000_0000 → grant_o=0001, start_xfr_o pulses 1 cycle, cmd_o=40'h40_0000_0000. Finish 5 cycles later → done_o=0001, status_o=4'b0011.
2. init_done_i=1, req_i=4'b1110 held, each finish returned → grant order 0010, 0100, 1000, 0010. After reset the pointer starts at 3, so the first grant is requester 1.
3. command_inhibit_i=1 for 20 cycles after grant → start_xfr_o stays 0 until the cycle inhibit drops, then pulses once.
4. No finish_i with FIN_TIMEOUT=16 → done_o exactly 16 cycles after start_xfr_o, status_o=4'b0100.
5. busy_chk_i[3]=1, busy_i held low 100 cycles after finish → done_o[3] pulses 1 cycle after busy_i rises, status_o[3]=0. With busy_i held low past BUSY_TIMEOUT → status_o[3]=1.
6. sd_rst_n asserted in WAIT_BUSY → all outputs 0 asynchronously, no done_o. After release, a pending req_i[2] is granted.
